rr_arbiter_8: RTL and testbench

Round-robin arbiter that shares a single resource between eight requesters and drives a one-hot grant bus. The winner is held as a 3-bit encoded index and expanded to one-hot through the existing `decoder_3to8`, the decoder's first sequenced consumer. It sits between up to eight request sources and a shared datapath (bus, register port, ALU), so that exactly one source owns the resource in any cycle.

---
 rtl/rr_arbiter_8_pkg.sv | 19 +
 rtl/rr_arbiter_8_decoder.sv | 16 +
 rtl/rr_arbiter_8.sv | 104 ++++++++++
 tb/tb_rr_arbiter_8.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   state_t       : FSM state encoding (IDLE = 0, GRANT = 1)
//   NUM_REQ/IDX_W : requester count and encoded index width
//   HOLD_CNT_W    : width of the per-grant hold counter
//   HOLD_MAX_MIN/HOLD_MAX_MAX : legal bounds of the HOLD_MAX parameter
package rr_arbiter_8_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned NUM_REQ      = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned HOLD_CNT_W   = 4;
  localparam int unsigned HOLD_MAX_MIN = 1;
  localparam int unsigned HOLD_MAX_MAX = 15;

endpackage

// File: rtl/rr_arbiter_8_decoder.sv
// 3-to-8 one-hot decoder used to expand the arbiter's encoded winner.
//   a, b, c : select bits, a is the MSB
//   y       : one-hot output, y[{a,b,c}] = 1
module decoder_3to8 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    y[{a, b, c}] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one resource among eight requesters.
//   HOLD_MAX  : max consecutive cycles one requester may hold the grant (1..15)
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   req       : level-sensitive request vector, req[i] is requester i
//   gnt       : one-hot grant, zero when no grant is active
//   gnt_valid : high while a grant is active
//   gnt_idx   : encoded winner index, meaningful while gnt_valid is high
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic                gnt_valid,
  output logic [IDX_W-1:0]    gnt_idx
);

  if (HOLD_MAX < HOLD_MAX_MIN || HOLD_MAX > HOLD_MAX_MAX) begin : g_bad_hold_max
    $error("rr_arbiter_8: HOLD_MAX must be within 1..15");
  end

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [HOLD_CNT_W-1:0]  hold_cnt;

  logic [IDX_W-1:0]       search_start;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_found;
  logic [IDX_W-1:0]       scan_idx;
  logic                   release_gnt;
  logic [NUM_REQ-1:0]     dec_y;

  // On release the pointer update and the search happen in the same cycle,
  // so the search starts from gnt_idx+1 directly rather than from ptr.
  assign search_start = (state == GRANT) ? gnt_idx + 1'b1 : ptr;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = search_start + IDX_W'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign release_gnt = !req[gnt_idx] || (hold_cnt == HOLD_CNT_W'(HOLD_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt_idx   <= win_idx;
            hold_cnt  <= HOLD_CNT_W'(1);
            gnt_valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!release_gnt) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            ptr <= gnt_idx + 1'b1;
            if (win_found) begin
              gnt_idx  <= win_idx;
              hold_cnt <= HOLD_CNT_W'(1);
            end else begin
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  decoder_3to8 u_dec (
    .a (gnt_idx[2]),
    .b (gnt_idx[1]),
    .c (gnt_idx[0]),
    .y (dec_y)
  );

  assign gnt = dec_y & {NUM_REQ{gnt_valid}};

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       v;
    logic [2:0] idx;
    logic       ci;   // compare gnt_idx on this vector
  } vec_t;

  typedef struct {
    int         n;
    logic [7:0] gnt;
    logic       v;
    logic [2:0] idx;
    logic       ci;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  rr_arbiter_8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] g,
                     input logic v, input logic [2:0] idx, input logic ci);
    vec_t t;
    t.rst = r; t.req = rq; t.gnt = g; t.v = v; t.idx = idx; t.ci = ci;
    vecs.push_back(t);
  endtask

  // Monitor: compares the registered outputs just after every active edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt) begin
        failures++;
        $display("FAIL v%0d gnt got=%h exp=%h", e.n, gnt, e.gnt);
      end
      checks++;
      if (gnt_valid !== e.v) begin
        failures++;
        $display("FAIL v%0d gnt_valid got=%b exp=%b", e.n, gnt_valid, e.v);
      end
      if (e.ci) begin
        checks++;
        if (gnt_idx !== e.idx) begin
          failures++;
          $display("FAIL v%0d gnt_idx got=%0d exp=%0d", e.n, gnt_idx, e.idx);
        end
      end
    end
  end

  initial begin
    exp_t e;
    // Reset with all requesting, then first grant to 0 from ptr=0
    add(1, 8'hFF, 8'h00, 0, 0, 1);
    add(1, 8'hFF, 8'h00, 0, 0, 1);
    add(0, 8'hFF, 8'h01, 1, 0, 1);
    add(0, 8'h00, 8'h00, 0, 0, 0);
    // Single requester 5: four grant cycles, timeout release with no other winner
    add(0, 8'h20, 8'h20, 1, 5, 1);
    add(0, 8'h20, 8'h20, 1, 5, 1);
    add(0, 8'h20, 8'h20, 1, 5, 1);
    add(0, 8'h20, 8'h20, 1, 5, 1);
    add(0, 8'h00, 8'h00, 0, 0, 0);
    // Rotation 7 <-> 0 (ptr=6 so 7 wins first), holders drop after one cycle
    add(0, 8'h81, 8'h80, 1, 7, 1);
    add(0, 8'h01, 8'h01, 1, 0, 1);
    add(0, 8'h80, 8'h80, 1, 7, 1);
    add(0, 8'h01, 8'h01, 1, 0, 1);
    add(0, 8'h80, 8'h80, 1, 7, 1);
    add(0, 8'h00, 8'h00, 0, 0, 0);
    // Timeout handover 1 -> 2 -> 1, no gap
    add(0, 8'h06, 8'h02, 1, 1, 1);
    add(0, 8'h06, 8'h02, 1, 1, 1);
    add(0, 8'h06, 8'h02, 1, 1, 1);
    add(0, 8'h06, 8'h02, 1, 1, 1);
    add(0, 8'h06, 8'h04, 1, 2, 1);
    add(0, 8'h06, 8'h04, 1, 2, 1);
    add(0, 8'h06, 8'h04, 1, 2, 1);
    add(0, 8'h06, 8'h04, 1, 2, 1);
    add(0, 8'h06, 8'h02, 1, 1, 1);
    add(0, 8'h00, 8'h00, 0, 0, 0);
    // Sole holder 3 re-granted continuously across timeout
    add(0, 8'h08, 8'h08, 1, 3, 1);
    add(0, 8'h08, 8'h08, 1, 3, 1);
    add(0, 8'h08, 8'h08, 1, 3, 1);
    add(0, 8'h08, 8'h08, 1, 3, 1);
    add(0, 8'h08, 8'h08, 1, 3, 1);
    add(0, 8'h08, 8'h08, 1, 3, 1);
    // Holder 3 drops while 4 requests: same-cycle handover, then reset mid-grant
    add(0, 8'h10, 8'h10, 1, 4, 1);
    add(0, 8'h10, 8'h10, 1, 4, 1);
    add(1, 8'h10, 8'h00, 0, 0, 1);
    add(0, 8'h10, 8'h10, 1, 4, 1);
    add(0, 8'h00, 8'h00, 0, 0, 0);
    // ptr=5: requests 2 and 3 -> 2 is closest going 5,6,7,0,1,2
    add(0, 8'h0C, 8'h04, 1, 2, 1);
    add(0, 8'h08, 8'h08, 1, 3, 1);
    add(0, 8'h00, 8'h00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      req = vecs[i].req;
      e.n = i; e.gnt = vecs[i].gnt; e.v = vecs[i].v;
      e.idx = vecs[i].idx; e.ci = vecs[i].ci;
      exp_q.push_back(e);
    end

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
